// File: rtl/ram_loader.sv
// ram_loader: packs a byte stream big-endian into 32-bit words and writes them to RAM from BASE.
// Define RAM_LOADER_VERIFY_EN to read back each written word and flag mismatches on err.
module ram_loader #(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          WORDS = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] ram_a,
   output logic [31:0] d_t_ram,
   output logic        wram,
   input  logic [31:0] d_f_ram,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, RECV, WRITE, VERIFY, DONE} state_t;
   state_t      state;
   logic [7:0]  n;
   logic [7:0]  idx;
   logic [1:0]  cnt;
   logic [23:0] sh;
   logic        last;
   assign last     = idx == n - 8'd1;
   assign rx_ready = state == RECV;
   assign wram     = state == WRITE;
   assign busy     = state != IDLE;
   assign cpu_hold = state != IDLE;
   assign done     = state == DONE;
`ifndef RAM_LOADER_VERIFY_EN
   logic unused_rd;
   assign unused_rd = ^d_f_ram;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         n       <= '0;
         idx     <= '0;
         cnt     <= '0;
         sh      <= '0;
         ram_a   <= '0;
         d_t_ram <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               n     <= (len > 8'(WORDS)) ? 8'(WORDS) : len;
               idx   <= '0;
               cnt   <= '0;
               err   <= 1'b0;
               state <= (len == 8'd0) ? DONE : RECV;
            end
            RECV: if (rx_valid) begin
               cnt <= cnt + 2'd1;
               sh  <= {sh[15:0], rx_data};
               if (cnt == 2'd3) begin
                  d_t_ram <= {sh, rx_data};
                  ram_a   <= BASE + {22'b0, idx, 2'b00};
                  state   <= WRITE;
               end
            end
`ifdef RAM_LOADER_VERIFY_EN
            WRITE: state <= VERIFY;
            VERIFY: begin
               if (d_f_ram != d_t_ram) err <= 1'b1;
               state <= last ? DONE : RECV;
               if (!last) idx <= idx + 8'd1;
            end
`else
            WRITE: begin
               state <= last ? DONE : RECV;
               if (!last) idx <= idx + 8'd1;
            end
`endif
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader; expected writes queued per load, checked at each wram.
// Honours RAM_LOADER_VERIFY_EN for cycle timing and the read-back error scenario.
module tb_ram_loader;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WORDS = 128;
`ifdef RAM_LOADER_VERIFY_EN
   localparam int PW = 6;
`else
   localparam int PW = 5;
`endif
   logic        clk = 1'b0;
   logic        rst, start, rx_valid, rx_ready, wram, cpu_hold, busy, done, err;
   logic [7:0]  len, rx_data;
   logic [31:0] ram_a, d_t_ram, d_f_ram;
   logic [31:0] mem [WORDS];
   logic        corrupt;
   typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
   wr_t         exp_q[$];
   int          n_checks = 0, n_fail = 0, n_wr = 0;
   logic [31:0] last_a;

   always #5 clk = ~clk;

   ram_loader #(.BASE(BASE), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .ram_a(ram_a), .d_t_ram(d_t_ram),
      .wram(wram), .d_f_ram(d_f_ram), .cpu_hold(cpu_hold), .busy(busy),
      .done(done), .err(err)
   );

   // word 0 reads back inverted while corrupt is set
   assign d_f_ram = (corrupt && ram_a == BASE) ? ~mem[ram_a[8:2]] : mem[ram_a[8:2]];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && wram) begin
         wr_t e;
         mem[ram_a[8:2]] = d_t_ram;
         n_wr++;
         last_a = ram_a;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_write: got addr %h data %h expected no write", ram_a, d_t_ram);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", ram_a, e.a);
            check("wr_data", d_t_ram, e.d);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready) begin
         @(negedge clk);
         if (++w > 1000) begin
            $display("FAIL rx_ready_timeout: got 0 expected 1");
            $fatal(1);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      rx_valid = 1'b0;
      repeat (k) @(negedge clk);
   endtask

   task automatic run_load(input logic [7:0] l, input logic [7:0] b[$], input int gap,
                           input bit pulse, input logic exp_err);
      int n, lat;
      n = (l > 8'(WORDS)) ? WORDS : int'(l);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{BASE + 32'(4 * i), {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]}});
      n_wr = 0;
      @(negedge clk);
      start = 1'b1;
      len   = l;
      fork
         begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 4 * n; i++) begin
               if (gap == 1 && i == 2) idle(3);
               if (gap == 2 && $urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
               send_byte(b[i]);
            end
            rx_valid = 1'b0;
         end
         begin
            lat = 0;
            @(posedge clk);
            lat = 1;
            forever begin
               @(negedge clk);
               if (done || lat > 5000) break;
               @(posedge clk);
               lat++;
            end
         end
         begin
            if (pulse) begin
               repeat (7) @(negedge clk);
               start = 1'b1;
               len   = 8'd3;
               @(negedge clk);
               start = 1'b0;
               len   = l;
            end
         end
      join
      if (lat > 5000) check("done_timeout", 32'(lat), 32'(1 + PW * n));
      else if (gap == 0) check("done_latency", 32'(lat), 32'(1 + PW * n));
      check("err_at_done", {31'b0, err}, {31'b0, exp_err});
      @(negedge clk);
      check("write_count", 32'(n_wr), 32'(n));
      check("writes_pending", 32'(exp_q.size()), 32'd0);
      check("cpu_hold_after", {31'b0, cpu_hold}, 32'd0);
      check("busy_after", {31'b0, busy}, 32'd0);
      check("err_after", {31'b0, err}, {31'b0, exp_err});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
      check({tag, "_wram"}, {31'b0, wram}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_err"}, {31'b0, err}, 32'd0);
      check({tag, "_ram_a"}, ram_a, 32'd0);
      check({tag, "_d_t_ram"}, d_t_ram, 32'd0);
   endtask

   initial begin
      logic [7:0] bq[$];
      for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
      rst = 1'b1; start = 1'b0; len = 8'd0; rx_valid = 1'b0; rx_data = 8'd0; corrupt = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      bq = '{8'h20, 8'h1D, 8'h02, 8'h00, 8'h20, 8'h10, 8'h00, 8'h00};
      run_load(8'd2, bq, 0, 1'b0, 1'b0);
      check("ram_word0", mem[0], 32'h201D0200);
      check("ram_word1", mem[1], 32'h20100000);

      mem[0] = 32'd0;
      run_load(8'd1, bq, 1, 1'b0, 1'b0);
      check("gap_word0", mem[0], 32'h201D0200);

      run_load(8'd0, bq, 0, 1'b0, 1'b0);

      bq = {};
      for (int i = 0; i < 4 * WORDS; i++) bq.push_back(8'($urandom));
      run_load(8'd200, bq, 0, 1'b0, 1'b0);
      check("sat_last_addr", last_a, BASE + 32'h1FC);

      bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      run_load(8'd2, bq, 0, 1'b1, 1'b0);

      // reset after one full word and half of the next
      exp_q.push_back('{BASE, 32'h11223344});
      n_wr = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      start = 1'b0;
      foreach (bq[i]) bq[i] = 8'h11 * 8'(i + 1);
      for (int i = 0; i < 6; i++) send_byte(bq[i]);
      rx_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check_all_zero("midreset");
      check("midreset_writes", 32'(n_wr), 32'd1);
      check("midreset_ram0", mem[0], 32'h11223344);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      run_load(8'd1, bq, 0, 1'b0, 1'b0);
      check("reload_ram0", mem[0], 32'hA1B2C3D4);

      for (int t = 0; t < 6; t++) begin
         logic [7:0] l;
         l  = 8'($urandom_range(1, 5));
         bq = {};
         for (int i = 0; i < 4 * int'(l); i++) bq.push_back(8'($urandom));
         run_load(l, bq, 2, 1'b0, 1'b0);
      end

`ifdef RAM_LOADER_VERIFY_EN
      corrupt = 1'b1;
      bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_load(8'd2, bq, 0, 1'b0, 1'b1);
      corrupt = 1'b0;
      @(negedge clk);
      start = 1'b1;
      len   = 8'd0;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared", {31'b0, err}, 32'd0);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_loader.md
# ram_loader

Boot loader that fills the unified instruction/data RAM over its write port (`ram_a`, `d_t_ram`, `wram`) from a byte stream, while holding the CPU off the bus. It sits between the host byte link (UART receiver or test harness) and the RAM's data-side port. It is multiplexed onto that port by `cpu_hold`. Bytes are packed big-endian into 32-bit words and written to consecutive word addresses starting at `BASE`.

## Interface
- `BASE`, 32'h0000_0000, byte address of the first word written; word-aligned.
- `WORDS`, 128, RAM capacity in words; caps the load length.

- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `len`  in  8  words to load, sampled with `start`; 0 = no writes; values > `WORDS` saturate to `WORDS`.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; transfer on posedge when `rx_valid & rx_ready`.
- `ram_a`  out  32  RAM byte address (`BASE + 4*word_idx`).
- `d_t_ram`  out  32  word to write.
- `wram`  out  1  RAM write strobe; the RAM commits on the negedge inside the cycle.
- `d_f_ram`  in  32  RAM read data at `ram_a` (combinational); used only for verify.
- `cpu_hold`  out  1  high while a load is in progress; the top level gives the RAM port to the loader.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at load end.
- `err`  out  1  sticky verify mismatch; cleared on accepted `start`.

## Operation
- States: IDLE, RECV, WRITE, VERIFY (macro only), DONE.
- IDLE:
  - On `start`, latch the effective length `n`, clear `word_idx`, byte count and `err`.
  - If `n == 0`, go to DONE; otherwise go to RECV.
- RECV:
  - `rx_ready = 1`.
  - Each accepted byte shifts into the word register: first byte → bits 31:24, fourth byte → bits 7:0.
  - After the 4th accepted byte, go to WRITE.
  - Stalls indefinitely while `rx_valid = 0`.
- WRITE:
  - `wram = 1` for exactly one cycle.
  - `ram_a = BASE + 4*word_idx`, `d_t_ram` = assembled word.
  - Next state is VERIFY (macro) or the advance step.
- Advance step: if `word_idx == n-1`, go to DONE; otherwise increment `word_idx` and return to RECV.
- DONE: `done = 1` for one cycle, then IDLE.
- `rx_ready`, `wram`, `busy`, `cpu_hold` and `done` decode from the state register only; there is no combinational path from `rx_valid` or `start`.
- `ram_a` and `d_t_ram` are registered and hold their last values in IDLE.
- `start` is ignored outside IDLE.
- Bytes presented outside RECV are not accepted.
- `cpu_hold` is high in RECV, WRITE, VERIFY and DONE.
- Reset mid-load:
  - Immediate return to IDLE; the partial word is discarded.
  - Words already written stay in RAM.
  - Reset values of all outputs apply.
- Reset values: `rx_ready`, `wram`, `busy`, `cpu_hold`, `done`, `err` = 0; `ram_a`, `d_t_ram` = 0.

## Timing
- `start` in cycle T: state RECV and `rx_ready = 1` in T+1.
- Per word with `rx_valid` held high: 4 RECV cycles + 1 WRITE cycle = 5 cycles, or 6 with VERIFY.
- Full load of `n` words with continuous data: `done` is asserted 1 + 5n cycles after the `start` edge (1 + 6n with verify).
- `len = 0`: `done` is asserted in T+1 and no `wram` pulse occurs.
- The `wram` pulse is one full clock cycle. Address and data are stable from the posedge before the RAM's negedge write to the posedge after it.

## Configuration
- `RAM_LOADER_VERIFY_EN` defined:
  - After each WRITE, the loader enters VERIFY for one cycle with `wram = 0` and `ram_a` unchanged.
  - It compares `d_f_ram` against the written word at the posedge.
  - On mismatch, `err` is set; it is sticky until the next accepted `start`.
  - The load continues regardless of `err`.
- Not defined:
  - No VERIFY state; WRITE advances directly.
  - `err` is tied 0 and `d_f_ram` is ignored.
  - The port list is identical in both builds.

## Test plan
- Reset, then `start` with `len = 2`; stream bytes 20 1D 02 00 20 10 00 00 with `rx_valid` held → RAM[BASE] = 32'h201D0200, RAM[BASE+4] = 32'h20100000; `done` 11 cycles after `start` (13 with verify); `cpu_hold` low afterwards.
- Drive `rx_valid` low for 3 cycles between bytes 2 and 3 → no byte lost or duplicated; the written word is unchanged from the gapless case; `wram` is not asserted early.
- `len = 0` → `done` the next cycle, zero `wram` pulses; `len = 200` → exactly 128 writes with the last at `BASE + 0x1FC`.
- Assert `rst` after word 1 plus 2 bytes of word 2 → all outputs 0 immediately; the word-1 RAM contents are preserved; a new `start` reloads from `BASE`.
- Pulse `start` while `busy` → ignored; `len` is not relatched and the load completes unchanged.
- Verify build: force `d_f_ram` to a wrong value during VERIFY of word 0 → `err = 1` from the next cycle and stays 1 through `done`; the next `start` clears it.
